// File: rtl/prio_rr_arbiter.sv
// Registered N-way arbiter with per-cycle selectable fixed-priority or round-robin
// selection, presenting the winner as index + one-hot under a valid/ready handshake.
module prio_rr_arbiter #(
  parameter int N = 16,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         mode,
  input  logic [N-1:0] req,
  input  logic         grant_ready,
  output logic         grant_valid,
  output logic [W-1:0] grant_idx,
  output logic [N-1:0] grant_onehot,
  output logic [15:0]  grant_count
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t       state;
  logic [W-1:0] ptr;
  logic         hs;
  logic [W-1:0] base;
  logic         win_found;
  logic [W-1:0] win_idx;

  // Search order base-1 .. 0, N-1 .. base: the highest requester below base wins,
  // otherwise the highest requester at or above base. Fixed priority is base = 0.
  function automatic logic [W:0] pick(input logic [N-1:0] r, input logic [W-1:0] b);
    logic         hit_lo, hit_hi;
    logic [W-1:0] lo, hi;
    hit_lo = 1'b0;
    hit_hi = 1'b0;
    lo     = '0;
    hi     = '0;
    for (int i = 0; i < N; i++) begin
      if (r[i]) begin
        if (W'(i) < b) begin
          hit_lo = 1'b1;
          lo     = W'(i);
        end else begin
          hit_hi = 1'b1;
          hi     = W'(i);
        end
      end
    end
    if (hit_lo) return {1'b1, lo};
    else        return {hit_hi, hi};
  endfunction

  always_comb begin
    hs   = (state == GRANT) && grant_ready;
    base = '0;
    if (mode) base = hs ? grant_idx : ptr;
    {win_found, win_idx} = pick(req, base);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      grant_valid  <= 1'b0;
      grant_idx    <= '0;
      grant_onehot <= '0;
      grant_count  <= '0;
      ptr          <= '0;
    end else begin
      if (hs) begin
        grant_count <= grant_count + 16'd1;
        ptr         <= grant_idx;
      end
      // A stalled grant holds idx/onehot regardless of req.
      if (state == IDLE || hs) begin
        if (win_found) begin
          state        <= GRANT;
          grant_valid  <= 1'b1;
          grant_idx    <= win_idx;
          grant_onehot <= N'(1) << win_idx;
        end else begin
          state        <= IDLE;
          grant_valid  <= 1'b0;
          grant_onehot <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_prio_rr_arbiter.sv
// Directed bench for prio_rr_arbiter (N = 16) with hand-computed grant sequences.
module tb_prio_rr_arbiter;
  localparam int N = 16;
  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic         mode;
  logic [N-1:0] req;
  logic         grant_ready;
  logic         grant_valid;
  logic [W-1:0] grant_idx;
  logic [N-1:0] grant_onehot;
  logic [15:0]  grant_count;

  int checks   = 0;
  int failures = 0;

  prio_rr_arbiter #(.N(N)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mode        (mode),
    .req         (req),
    .grant_ready (grant_ready),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx),
    .grant_onehot(grant_onehot),
    .grant_count (grant_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_grant(input string tag, input logic v, input logic [W-1:0] idx,
                           input logic [N-1:0] oh, input logic [15:0] cnt);
    chk({tag, ".valid"}, 64'(grant_valid), 64'(v));
    chk({tag, ".idx"}, 64'(grant_idx), 64'(idx));
    chk({tag, ".onehot"}, 64'(grant_onehot), 64'(oh));
    chk({tag, ".count"}, 64'(grant_count), 64'(cnt));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; mode = 1'b0; req = '0; grant_ready = 1'b0;
    tick(); tick();
    chk_grant("reset", 1'b0, 4'd0, 16'h0000, 16'd0);

    // Single request
    rst_n = 1'b1; req = 16'h0001; grant_ready = 1'b1;
    tick();
    chk_grant("single", 1'b1, 4'd0, 16'h0001, 16'd0);
    req = '0;
    tick();
    chk_grant("single_acc", 1'b0, 4'd0, 16'h0000, 16'd1);

    // Fixed priority with 3-cycle stall; req changes are ignored
    mode = 1'b0; req = 16'h8421; grant_ready = 1'b0;
    tick();
    chk_grant("fix_stall0", 1'b1, 4'd15, 16'h8000, 16'd1);
    req = 16'h0001;
    tick();
    chk_grant("fix_stall1", 1'b1, 4'd15, 16'h8000, 16'd1);
    tick();
    chk_grant("fix_stall2", 1'b1, 4'd15, 16'h8000, 16'd1);
    req = '0; grant_ready = 1'b1;
    tick();
    chk_grant("fix_drain", 1'b0, 4'd15, 16'h0000, 16'd2);

    // Round-robin rotation from a fresh reset
    #3 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    mode = 1'b1; req = 16'h8421; grant_ready = 1'b1;
    tick(); chk_grant("rr0", 1'b1, 4'd15, 16'h8000, 16'd0);
    tick(); chk_grant("rr1", 1'b1, 4'd10, 16'h0400, 16'd1);
    tick(); chk_grant("rr2", 1'b1, 4'd5,  16'h0020, 16'd2);
    tick(); chk_grant("rr3", 1'b1, 4'd0,  16'h0001, 16'd3);
    tick(); chk_grant("rr4", 1'b1, 4'd15, 16'h8000, 16'd4);
    tick(); chk_grant("rr5", 1'b1, 4'd10, 16'h0400, 16'd5);

    // Mode switch: accept 10 under fixed mode, then accept 15 under round-robin
    mode = 1'b0;
    tick(); chk_grant("sw_fix", 1'b1, 4'd15, 16'h8000, 16'd6);
    mode = 1'b1;
    tick(); chk_grant("sw_rr", 1'b1, 4'd10, 16'h0400, 16'd7);

    // Run rotation up to count 0xFFFE, then wrap and drain
    repeat (16'hFFFE - 7) @(posedge clk);
    #1;
    chk_grant("pre_wrap", 1'b1, 4'd15, 16'h8000, 16'hFFFE);
    tick(); chk_grant("wrap_ffff", 1'b1, 4'd10, 16'h0400, 16'hFFFF);
    tick(); chk_grant("wrap_0000", 1'b1, 4'd5,  16'h0020, 16'h0000);
    req = '0;
    tick(); chk_grant("wrap_drain", 1'b0, 4'd5, 16'h0000, 16'h0001);

    // IDLE with ptr = 5: round-robin picks 0 first; ready in IDLE has no effect
    req = 16'h8421; grant_ready = 1'b0;
    tick(); chk_grant("ptr_resume", 1'b1, 4'd0, 16'h0001, 16'h0001);

    // Asynchronous reset between edges while a grant is presented
    #3 rst_n = 1'b0;
    #1 chk_grant("async_rst", 1'b0, 4'd0, 16'h0000, 16'h0000);
    rst_n = 1'b1; req = 16'h0006; mode = 1'b1;
    tick(); chk_grant("post_rst", 1'b1, 4'd2, 16'h0004, 16'd0);

    // Accepted requester wins again only as the sole requester
    req = 16'h0004; grant_ready = 1'b1;
    tick(); chk_grant("sole_again", 1'b1, 4'd2, 16'h0004, 16'd1);
    req = 16'h0006;
    tick(); chk_grant("not_again", 1'b1, 4'd1, 16'h0002, 16'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/prio_rr_arbiter.md
# prio_rr_arbiter

Registered, parametrised N-way arbiter: the sequential successor to the 16-to-4 priority encoder / 4-to-16 decoder pair. Each cycle it selects one requester from a request vector. Selection uses either fixed priority (highest index wins) or round-robin, chosen per cycle by a mode input. The winner is presented as both a binary index and a one-hot vector under a valid/ready handshake. It sits between groups of requesting units and a shared resource (bus port, memory bank) and replaces the combinational encoder/decoder pair wherever fairness or back-pressure is needed.

## Interface
Parameters:
- N, 16, number of requesters; legal range 2..64, power of two not required
- W, $clog2(N), width of grant_idx; derived, never overridden

Ports:
- clk  input  1  single clock; all state updates on its rising edge
- rst_n  input  1  reset; asynchronous, active-low
- mode  input  1  0 = fixed priority, 1 = round-robin
- req  input  N  request vector; bit i = requester i wants the resource
- grant_ready  input  1  consumer accepts the presented grant this cycle
- grant_valid  output  1  a grant is presented
- grant_idx  output  W  binary index of the granted requester
- grant_onehot  output  N  one-hot form of grant_idx; all-zero whenever grant_valid = 0
- grant_count  output  16  number of accepted grants; wraps 0xFFFF -> 0x0000

## Operation
- Reset values: grant_valid = 0, grant_idx = 0, grant_onehot = 0, grant_count = 0, internal pointer ptr = 0.
- Two states:
  - IDLE (grant_valid = 0)
  - GRANT (grant_valid = 1)
- Arbitration is evaluated when the block is in IDLE, or in GRANT with grant_ready = 1 (a handshake).
- Fixed mode: the highest set index of req wins.
- Round-robin mode:
  - Search order is base-1, base-2, …, 0, N-1, …, base; the first set bit wins.
  - base = grant_idx in a handshake cycle; base = ptr in IDLE.
  - With ptr = 0 after reset, round-robin order equals fixed order.
- ptr <= grant_idx on every handshake, in both modes. A mode change therefore never loses fairness history; the new mode takes effect at the next arbitration.
- Transitions:
  - IDLE and req != 0 -> GRANT; winner registered.
  - IDLE and req == 0 -> IDLE.
  - GRANT and grant_ready = 0 -> GRANT; grant_idx and grant_onehot held stable. req changes, including the granted bit dropping, are ignored.
  - GRANT and grant_ready = 1 and req != 0 -> GRANT with the new winner (back-to-back; grant_valid stays 1).
  - GRANT and grant_ready = 1 and req == 0 -> IDLE; grant_onehot -> 0, grant_idx retains its last value.
- grant_count increments by 1 on every handshake; 16-bit wrap-around, no saturation.
- grant_ready while in IDLE has no effect.
- In round-robin mode the currently accepted requester may win again only if it is the sole requester.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Latency: a req asserted in cycle t while IDLE gives grant_valid = 1 in cycle t+1.
- Throughput: one grant per cycle when grant_ready is held at 1 and req != 0.
- Handshake: a transfer occurs in a cycle where grant_valid & grant_ready = 1, sampled at the rising edge.
- Asserting rst_n = 0 mid-grant clears all outputs and ptr immediately, without waiting for a clock edge. The first arbitration happens on the first rising edge after rst_n deasserts.
- mode and req are sampled only at arbitration edges.

## Test plan
- Reset / single request: hold rst_n = 0, check all outputs are 0; release it and drive req = 0x0001 with ready = 1. Next cycle: valid = 1, idx = 0, onehot = 0x0001, count -> 1.
- Fixed priority with stall: mode = 0, req = 0x8421, ready = 0 for 3 cycles. Required: idx = 15 and onehot = 0x8000, stable for all 3 cycles, even when req changes to 0x0001 during the stall.
- Round-robin rotation: mode = 1, req = 0x8421 held, ready = 1. Required grant sequence is idx 15, 10, 5, 0, 15, with valid continuously 1 and count = 5.
- Mode switch: run round-robin until idx = 10 is accepted, then set mode = 0 with req = 0x8421. Next grant is idx = 15. Switch back to mode = 1 after accepting 15; the next grant is 10.
- Drain and wrap-around: preload 0xFFFE grants, then issue 3 more handshakes with req dropping to 0 after the last one. Required: count goes 0xFFFF, then 0x0000, then 0x0001; valid -> 0; onehot = 0; idx holds its last value.
- Async reset mid-operation: pull rst_n low between clock edges while valid = 1. Outputs go to 0 before the next edge. After release with req = 0x0006, mode = 1, the first grant is idx = 2.
